// File: rtl/fft_pkg.sv
// Shared types for the 2-point FFT front end: complex sample, sample pair,
// and the pairer FSM states.
package fft_pkg;
    localparam int W = 16;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    typedef struct packed {
        cplx_t x0;
        cplx_t x1;
    } cplx_pair_t;

    typedef enum logic {
        EXPECT_X0 = 1'b0,
        EXPECT_X1 = 1'b1
    } pair_state_e;
endpackage

// File: rtl/fft2_sample_pairer_if.sv
// Sample-in / pair-out bundle of the pairer. master drives samples and
// consumes pairs; slave is the pairer itself.
interface fft2_sample_pairer_if #(parameter int DEPTH = 4) ();
    import fft_pkg::*;
    localparam int LW = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                in_first;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] x0r;
    logic signed [W-1:0] x0i;
    logic signed [W-1:0] x1r;
    logic signed [W-1:0] x1i;
    logic                drop_pulse;
    logic [LW-1:0]       level;

    modport master (
        output in_valid, in_re, in_im, in_first, out_ready,
        input  in_ready, out_valid, x0r, x0i, x1r, x1i, drop_pulse, level
    );

    modport slave (
        input  in_valid, in_re, in_im, in_first, out_ready,
        output in_ready, out_valid, x0r, x0i, x1r, x1i, drop_pulse, level
    );
endinterface

// File: rtl/fft2_pair_fifo.sv
// First-word-fall-through FIFO of sample pairs; head reads zero when empty.
module fft2_pair_fifo
    import fft_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  cplx_pair_t wr_data,
    input  logic       rd_en,
    output cplx_pair_t rd_data,
    output logic       full,
    output logic       empty,
    output logic [LW-1:0] level
);
    cplx_pair_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] cnt;
    logic          do_wr, do_rd;

    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;
    // Guards are belt-and-braces; the pairer never writes full or reads empty.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/fft2_sample_pairer.sv
// Groups a serial complex sample stream into (x0, x1) pairs for the 2-point
// butterfly, with in_first-driven realignment and a drop flag for orphaned x0.
module fft2_sample_pairer
    import fft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    fft2_sample_pairer_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    pair_state_e   state;
    cplx_t         hold;
    logic          drop_q;
    cplx_t         smp;
    cplx_pair_t    head;
    logic          full, empty, accept, wr, rd;
    logic [LW-1:0] level;

    assign smp = {bus.in_re, bus.in_im};

    // in_ready looks only at registered state, never at out_ready.
    assign bus.in_ready = (state == EXPECT_X0) || !full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wr           = accept && (state == EXPECT_X1) && !bus.in_first;
    assign rd           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EXPECT_X0;
            hold   <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (accept) begin
                case (state)
                    EXPECT_X0: begin
                        hold  <= smp;
                        state <= EXPECT_X1;
                    end
                    EXPECT_X1: begin
                        if (bus.in_first) begin
                            hold   <= smp;
                            drop_q <= 1'b1;
                        end else begin
                            state <= EXPECT_X0;
                        end
                    end
                    default: state <= EXPECT_X0;
                endcase
            end
        end
    end

    fft2_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data ({hold, smp}),
        .rd_en   (rd),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign bus.out_valid  = !empty;
    assign bus.x0r        = head.x0.re;
    assign bus.x0i        = head.x0.im;
    assign bus.x1r        = head.x1.re;
    assign bus.x1i        = head.x1.im;
    assign bus.drop_pulse = drop_q;
    assign bus.level      = level;
endmodule

// File: tb/tb_fft2_sample_pairer.sv
// Directed bench for fft2_sample_pairer plus a short randomised order check
// against a queue of expected pairs.
module tb_fft2_sample_pairer;
    logic clk;
    logic rst;
    int   nvec  = 0;
    int   nmiss = 0;

    fft2_sample_pairer_if #(.DEPTH(4)) bus ();

    fft2_sample_pairer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk(int a, int b, int c, int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmiss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int re, int im, bit first);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_re    = 16'(re);
        bus.in_im    = 16'(im);
        bus.in_first = first;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            nvec++;
            nmiss++;
            $error("FAIL send_timeout: in_ready observed 0 expected 1");
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    function automatic logic [63:0] headv();
        return {bus.x0r, bus.x0i, bus.x1r, bus.x1i};
    endfunction

    logic [63:0] exp_q[$];
    logic [63:0] obs_h;
    logic [31:0] pend;
    logic        half, acc, rdv;
    int          issued, got, cyc, a;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0;
        bus.in_first = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_head",      headv(), 64'd0);
        chk("rst_drop",      64'(bus.drop_pulse), 64'd0);
        chk("rst_level",     64'(bus.level), 64'd0);
        rst = 1'b0;

        // (1,0),(2,0): pair visible one cycle after x1 accept
        send(1, 0, 1'b1);
        send(2, 0, 1'b0);
        chk("p1_valid", 64'(bus.out_valid), 64'd1);
        chk("p1_head",  headv(), mk(1, 0, 2, 0));
        chk("p1_level", 64'(bus.level), 64'd1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        chk("p1_drained_valid", 64'(bus.out_valid), 64'd0);
        chk("p1_drained_head",  headv(), 64'd0);

        // (10,5),(0,-5) with downstream always ready
        bus.out_ready = 1'b1;
        send(10, 5, 1'b0);
        send(0, -5, 1'b0);
        chk("p2_head",  headv(), mk(10, 5, 0, -5));
        tick();
        chk("p2_level", 64'(bus.level), 64'd0);
        bus.out_ready = 1'b0;

        // Fill: 8 samples fill 4 pairs, 9th held, 10th back-pressured
        for (int k = 1; k <= 9; k++) send(k, -k, k == 1);
        chk("fill_level", 64'(bus.level), 64'd4);
        chk("fill_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1; bus.in_re = 16'(10); bus.in_im = 16'(-10);
        tick();
        chk("fill_blocked_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_blocked_level", 64'(bus.level), 64'd4);
        chk("fill_head", headv(), mk(1, -1, 2, -2));
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        chk("free_level", 64'(bus.level), 64'd3);
        chk("free_ready", 64'(bus.in_ready), 64'd1);
        chk("free_head",  headv(), mk(3, -3, 4, -4));
        tick();
        bus.in_valid = 1'b0;
        chk("refill_level", 64'(bus.level), 64'd4);
        chk("refill_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a = 3 + 2 * j;
            chk("drain_head", headv(), mk(a, -a, a + 1, -(a + 1)));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("drain_level", 64'(bus.level), 64'd0);

        // Resync: A first, B first -> A dropped, then (B, C)
        send(100, 1, 1'b1);
        chk("rs_nodrop", 64'(bus.drop_pulse), 64'd0);
        send(200, 2, 1'b1);
        chk("rs_drop",       64'(bus.drop_pulse), 64'd1);
        chk("rs_drop_level", 64'(bus.level), 64'd0);
        tick();
        chk("rs_drop_clear", 64'(bus.drop_pulse), 64'd0);
        send(300, 3, 1'b0);
        chk("rs_head", headv(), mk(200, 2, 300, 3));
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

        // Reset mid-operation with x0 held and level 2
        send(1, 1, 1'b0); send(2, 2, 1'b0);
        send(3, 3, 1'b0); send(4, 4, 1'b0);
        send(5, 5, 1'b0);
        chk("mr_level_pre", 64'(bus.level), 64'd2);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_re = 16'(6); bus.in_im = 16'(6);
        tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        chk("mr_level", 64'(bus.level), 64'd0);
        chk("mr_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_ready", 64'(bus.in_ready), 64'd1);
        chk("mr_drop",  64'(bus.drop_pulse), 64'd0);
        send(7, 7, 1'b0);
        send(8, 8, 1'b0);
        chk("mr_head",  headv(), mk(7, 7, 8, 8));
        chk("mr_level_post", 64'(bus.level), 64'd1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

        // Simultaneous write and read at level 2
        send(11, 0, 1'b0); send(12, 0, 1'b0);
        send(13, 0, 1'b0); send(14, 0, 1'b0);
        send(15, 0, 1'b0);
        bus.out_ready = 1'b1;
        send(16, 0, 1'b0);
        chk("sim_level", 64'(bus.level), 64'd2);
        chk("sim_head",  headv(), mk(13, 0, 14, 0));
        tick();
        chk("sim_head2", headv(), mk(15, 0, 16, 0));
        tick();
        chk("sim_level_end", 64'(bus.level), 64'd0);
        bus.out_ready = 1'b0;

        // 20 random pairs with random stalls on both sides
        issued = 0; got = 0; cyc = 0; half = 1'b0; pend = '0;
        while ((issued < 40 || bus.in_valid || got < 20) && cyc < 2000) begin
            if (!bus.in_valid && issued < 40 && ($urandom % 4) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_re    = 16'($urandom);
                bus.in_im    = 16'($urandom);
                bus.in_first = 1'b0;
                issued++;
            end
            bus.out_ready = (issued >= 40) ? 1'b1 : 1'($urandom % 2);
            acc   = bus.in_valid && bus.in_ready;
            rdv   = bus.out_valid && bus.out_ready;
            obs_h = headv();
            if (acc) begin
                if (!half) pend = {bus.in_re, bus.in_im};
                else exp_q.push_back({pend, bus.in_re, bus.in_im});
                half = !half;
            end
            tick();
            if (rdv) begin
                if (exp_q.size() == 0) chk("rnd_unexpected_pair", obs_h, 64'hx);
                else chk("rnd_order", obs_h, exp_q.pop_front());
                got++;
            end
            if (acc) bus.in_valid = 1'b0;
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("rnd_pairs", 64'(got), 64'd20);
        chk("rnd_level", 64'(bus.level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
